shift_sequencer: RTL and testbench

//  Multi-cycle controller that computes the ARM operand-2 value (val2) iteratively, replacing the combinational

---
 rtl/shift_sequencer_if.sv | 37 +++
 rtl/shift_sequencer.sv | 135 +++++++++++++
 tb/tb_shift_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the operand-2 shift sequencer.
// master drives the operand request and out_ready; slave returns val2.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic        is_memory_ins;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;

  modport master (
    output in_valid,
    output val_rm,
    output imm,
    output shift_operand,
    output is_memory_ins,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  val2
  );

  modport slave (
    input  in_valid,
    input  val_rm,
    input  imm,
    input  shift_operand,
    input  is_memory_ins,
    input  out_ready,
    output in_ready,
    output out_valid,
    output val2
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative ARM operand-2 shifter: STEP bit positions per cycle.
// Ports: clk, rst_n, flush, bus (slave handshake bundle), stall.
module shift_sequencer #(
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_sequencer_if.slave bus,
  output logic             stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  localparam logic [4:0] STEP_W = 5'(STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  n_q, n_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] val2_q, val2_d;

  logic        accept;
  logic [31:0] ld_acc;
  logic [4:0]  ld_n;
  logic [1:0]  ld_op;
  logic [4:0]  k;
  logic [4:0]  n_left;
  logic [31:0] shifted;

  assign accept = bus.in_valid & (state_q == S_IDLE) & ~flush;

  always_comb begin
    ld_acc = bus.val_rm;
    ld_n   = bus.shift_operand[11:7];
    ld_op  = bus.shift_operand[6:5];
    unique case (1'b1)
      bus.is_memory_ins: begin
        ld_acc = {20'b0, bus.shift_operand};
        ld_n   = 5'd0;
        ld_op  = OP_LSL;
      end
      bus.imm & ~bus.is_memory_ins: begin
        ld_acc = {24'b0, bus.shift_operand[7:0]};
        ld_n   = {bus.shift_operand[11:8], 1'b0};
        ld_op  = OP_ROR;
      end
      default: ;
    endcase
  end

  // Last partial step only moves the remaining positions.
  assign k      = (n_q < STEP_W) ? n_q : STEP_W;
  assign n_left = n_q - k;

  always_comb begin
    shifted = acc_q;
    unique case (op_q)
      OP_LSL: shifted = acc_q << k;
      OP_LSR: shifted = acc_q >> k;
      OP_ASR: shifted = 32'($signed(acc_q) >>> k);
      OP_ROR: shifted = (acc_q >> k)
                      | (acc_q << (6'd32 - {1'b0, k}));
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    op_d    = op_q;
    val2_d  = val2_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_d = ld_acc;
            n_d   = ld_n;
            op_d  = ld_op;
            if (ld_n == 5'd0) begin
              state_d = S_DONE;
              val2_d  = ld_acc;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_d = shifted;
          n_d   = n_left;
          if (n_left == 5'd0) begin
            state_d = S_DONE;
            val2_d  = shifted;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      op_q    <= OP_LSL;
      val2_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      op_q    <= op_d;
      val2_q  <= val2_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.val2      = val2_q;
  assign stall         = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer, STEP=1 and STEP=4 side by side.
// Requests are modelled arithmetically and checked by a negedge monitor.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if b1();
  shift_sequencer_if b4();
  logic st1, st4;

  shift_sequencer #(.STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .bus(b1), .stall(st1)
  );
  shift_sequencer #(.STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .bus(b4), .stall(st4)
  );

  typedef struct {
    logic [31:0] v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic hold_ready = 1'b0;
  logic [31:0] lastv[2];
  logic seen[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void model(input logic [31:0] rm, input logic im,
                                input logic [11:0] so, input logic mem,
                                output logic [31:0] v, output int n);
    logic [63:0] t;
    longint sx;
    logic [31:0] x;
    int op;
    if (mem) begin
      v = {20'b0, so};
      n = 0;
      return;
    end
    if (im) begin
      x = {24'b0, so[7:0]};
      n = 2 * so[11:8];
      op = 3;
    end else begin
      x = rm;
      n = int'(so[11:7]);
      op = int'(so[6:5]);
    end
    case (op)
      0: v = x << n;
      1: v = x >> n;
      2: begin
        sx = longint'($signed(x));
        t = 64'(sx >>> n);
        v = t[31:0];
      end
      default: begin
        t = {x, x} >> n;
        v = t[31:0];
      end
    endcase
  endfunction

  always @(negedge clk) begin
    b1.out_ready = hold_ready ? 1'b0 : (($urandom % 4) != 0);
    b4.out_ready = hold_ready ? 1'b0 : (($urandom % 4) != 0);
  end

  task automatic mon(input int d, input logic ov, input logic [31:0] v,
                     input logic st);
    exp_t e;
    bit empty;
    if (!ov) begin
      seen[d] = 1'b0;
    end else if (!seen[d]) begin
      seen[d] = 1'b1;
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out dut%0d: got %h expected none", d, v);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("val2 dut%0d", d), v, e.v);
        chk($sformatf("latency dut%0d", d), 32'(cyc - e.acc), 32'(e.lat));
        chk($sformatf("stall_done dut%0d", d), 32'(st), 32'd1);
        lastv[d] = e.v;
      end
    end else begin
      chk($sformatf("val2_hold dut%0d", d), v, lastv[d]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
    end else begin
      mon(0, b1.out_valid, b1.val2, st1);
      mon(1, b4.out_valid, b4.val2, st4);
    end
  end

  task automatic drive(input logic v, input logic [31:0] rm,
                       input logic im, input logic [11:0] so,
                       input logic mem);
    b1.in_valid = v; b4.in_valid = v;
    b1.val_rm = rm; b4.val_rm = rm;
    b1.imm = im; b4.imm = im;
    b1.shift_operand = so; b4.shift_operand = so;
    b1.is_memory_ins = mem; b4.is_memory_ins = mem;
  endtask

  // Called just after a negedge with both DUTs idle.
  task automatic present(input logic [31:0] rm, input logic im,
                         input logic [11:0] so, input logic mem);
    exp_t e;
    logic [31:0] v;
    int n;
    model(rm, im, so, mem, v, n);
    e.v = v;
    e.acc = cyc;
    e.lat = n + 1;
    q0.push_back(e);
    e.lat = (n + 3) / 4 + 1;
    q1.push_back(e);
    drive(1'b1, rm, im, so, mem);
    @(posedge clk);
    #1;
    drive(1'b0, $urandom, 1'b0, 12'h0, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (b1.in_ready && b4.in_ready && q0.size() == 0 && q1.size() == 0)
        return;
      @(negedge clk);
    end
    checks++;
    errs++;
    $display("FAIL timeout: got busy expected idle");
    q0.delete();
    q1.delete();
  endtask

  task automatic run(input logic [31:0] rm, input logic im,
                     input logic [11:0] so, input logic mem);
    present(rm, im, so, mem);
    wait_idle();
  endtask

  task automatic check_reset();
    chk("rst in_ready1", 32'(b1.in_ready), 32'd1);
    chk("rst out_valid1", 32'(b1.out_valid), 32'd0);
    chk("rst stall1", 32'(st1), 32'd0);
    chk("rst val2_1", b1.val2, 32'd0);
    chk("rst in_ready4", 32'(b4.in_ready), 32'd1);
    chk("rst out_valid4", 32'(b4.out_valid), 32'd0);
    chk("rst stall4", 32'(st4), 32'd0);
    chk("rst val2_4", b4.val2, 32'd0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 12'h0, 1'b0);
    b1.out_ready = 1'b0;
    b4.out_ready = 1'b0;
    lastv[0] = 32'h0;
    lastv[1] = 32'h0;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    run($urandom, 1'b0, 12'hABC, 1'b1);
    run($urandom, 1'b1, 12'hABC, 1'b1);
    run($urandom, 1'b1, 12'h4FF, 1'b0);
    run(32'h80000010, 1'b0, {5'd4, 2'b10, 1'b0, 4'd0}, 1'b0);
    run(32'h80000010, 1'b0, {5'd4, 2'b01, 1'b0, 4'd0}, 1'b0);
    run(32'h00000001, 1'b0, {5'd1, 2'b11, 1'b0, 4'd0}, 1'b0);
    run(32'h00000001, 1'b0, {5'd31, 2'b11, 1'b0, 4'd0}, 1'b0);
    run(32'hDEADBEEF, 1'b0, {5'd0, 2'b10, 1'b0, 4'd0}, 1'b0);
    run(32'hFFFFFFFF, 1'b0, {5'd31, 2'b00, 1'b0, 4'd0}, 1'b0);
    run(32'h80000000, 1'b0, {5'd31, 2'b10, 1'b0, 4'd0}, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    hold_ready = 1'b1;
    @(negedge clk);
    present($urandom, 1'b1, 12'h4FF, 1'b0);
    for (int i = 0; i < 50 && !b1.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid1", 32'(b1.out_valid), 32'd1);
      chk("bp in_ready1", 32'(b1.in_ready), 32'd0);
      chk("bp val2_1", b1.val2, 32'hFF000000);
      chk("bp in_ready4", 32'(b4.in_ready), 32'd0);
      chk("bp val2_4", b4.val2, 32'hFF000000);
      @(negedge clk);
    end
    hold_ready = 1'b0;
    wait_idle();

    // Flush mid-SHIFT drops the op and keeps the old val2.
    present(32'h12345678, 1'b0, {5'd20, 2'b00, 1'b0, 4'd0}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    q0.delete();
    q1.delete();
    chk("flush stall1", 32'(st1), 32'd0);
    chk("flush in_ready1", 32'(b1.in_ready), 32'd1);
    chk("flush out_valid1", 32'(b1.out_valid), 32'd0);
    chk("flush val2_1", b1.val2, 32'hFF000000);
    chk("flush stall4", 32'(st4), 32'd0);
    chk("flush val2_4", b4.val2, 32'hFF000000);
    repeat (4) @(negedge clk);

    // A request alongside flush is not taken.
    flush = 1'b1;
    drive(1'b1, 32'h1, 1'b0, 12'hFFF, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 12'h0, 1'b0);
    @(negedge clk);
    chk("flush_acc stall1", 32'(st1), 32'd0);
    chk("flush_acc stall4", 32'(st4), 32'd0);
    repeat (3) @(negedge clk);

    // Async reset while shifting.
    present($urandom, 1'b1, 12'hEFF, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_reset();
    lastv[0] = 32'h0;
    lastv[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run($urandom, 1'($urandom % 2), 12'($urandom),
          1'(($urandom % 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
